// File: rtl/riscv_icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package riscv_icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    FILL  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_CORE_DATA_WIDTH = 32;
  localparam int unsigned DEF_LINE_WORDS      = 8;
  localparam int unsigned DEF_SETS            = 128;
  localparam int unsigned DEF_LINE_BITS       = DEF_LINE_WORDS * DEF_CORE_DATA_WIDTH;
  localparam int unsigned DEF_TAG_WIDTH       = DEF_ADDR_WIDTH - idx_width(DEF_SETS)
                                                - idx_width(DEF_LINE_WORDS) - 2;

  typedef logic [DEF_LINE_BITS-1:0]        line_t;
  typedef logic [DEF_TAG_WIDTH-1:0]        tag_t;
  typedef logic [idx_width(DEF_SETS)-1:0]  index_t;

endpackage

// File: rtl/riscv_icache_way.sv
// One cache way: valid bits, tag and line storage with combinational read.
module riscv_icache_way
  import riscv_icache_pkg::*;
#(
  parameter int unsigned SETS      = 128,
  parameter int unsigned TAG_WIDTH = 20,
  parameter int unsigned LINE_BITS = 256,
  localparam int unsigned IDX_W    = idx_width(SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_index,
  output logic                 valid,
  output logic [TAG_WIDTH-1:0] tag,
  output logic [LINE_BITS-1:0] line,
  input  logic                 we,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic                 clear
);

  logic [SETS-1:0]      valid_q;
  logic [TAG_WIDTH-1:0] tag_mem  [SETS];
  logic [LINE_BITS-1:0] data_mem [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Payload arrays are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign valid = valid_q[rd_index];
  assign tag   = tag_mem[rd_index];
  assign line  = data_mem[rd_index];

endmodule

// File: rtl/riscv_core_icache_assoc.sv
// Set-associative instruction cache: controller FSM, victim select, output mux.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module riscv_core_icache_assoc
  import riscv_icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned CORE_DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS      = 8,
  parameter int unsigned SETS            = 128,
  parameter int unsigned WAYS            = 2
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_req,
  input  logic [ADDR_WIDTH-1:0]                 i_addr,
  input  logic                                  i_flush,
  output logic                                  o_stall,
  output logic [CORE_DATA_WIDTH-1:0]            o_data,
  output logic                                  o_mem_req,
  output logic [ADDR_WIDTH-1:0]                 o_mem_addr,
  input  logic                                  i_mem_done,
  input  logic [LINE_WORDS*CORE_DATA_WIDTH-1:0] i_mem_block
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                           o_hit_cnt,
  output logic [31:0]                           o_miss_cnt
`endif
);

  localparam int unsigned LINE_BITS = LINE_WORDS * CORE_DATA_WIDTH;
  localparam int unsigned OFF_W     = idx_width(LINE_WORDS);
  localparam int unsigned IDX_W     = idx_width(SETS);
  localparam int unsigned LSB_W     = OFF_W + 2;
  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - IDX_W - LSB_W;
  localparam int unsigned WAY_W     = idx_width(WAYS);

  state_e                state;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [CORE_DATA_WIDTH-1:0] data_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  victim_rr_q;
  logic                  flush_pending;
  logic [WAY_W-1:0]      rr_ptr [SETS];

  logic [TAG_WIDTH-1:0]  req_tag;
  logic [IDX_W-1:0]      req_index;
  logic [OFF_W-1:0]      req_off;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [TAG_WIDTH-1:0]  miss_tag;
  logic [IDX_W-1:0]      miss_index;
  logic                  unused_addr_lsb;

  assign req_tag         = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_index       = i_addr[LSB_W +: IDX_W];
  assign req_off         = i_addr[2 +: OFF_W];
  assign line_addr       = {i_addr[ADDR_WIDTH-1:LSB_W], LSB_W'(0)};
  assign miss_tag        = mem_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign miss_index      = mem_addr_q[LSB_W +: IDX_W];
  assign unused_addr_lsb = ^i_addr[1:0];

  logic [WAYS-1:0]      way_valid;
  logic [WAYS-1:0]      hit_vec;
  logic [WAYS-1:0]      way_we;
  logic [TAG_WIDTH-1:0] way_tag  [WAYS];
  logic [LINE_BITS-1:0] way_line [WAYS];
  logic                 flush_now;
  logic                 install;
  logic                 flush_clr;

  assign flush_now = flush_pending | i_flush;
  assign install   = (state == MISS) && i_mem_done && !flush_now;
  assign flush_clr = (state == FLUSH);

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    riscv_icache_way #(
      .SETS      (SETS),
      .TAG_WIDTH (TAG_WIDTH),
      .LINE_BITS (LINE_BITS)
    ) u_way (
      .clk      (i_clk),
      .rst      (i_rst),
      .rd_index (req_index),
      .valid    (way_valid[g]),
      .tag      (way_tag[g]),
      .line     (way_line[g]),
      .we       (way_we[g]),
      .wr_index (miss_index),
      .wr_tag   (miss_tag),
      .wr_line  (i_mem_block),
      .clear    (flush_clr)
    );
    assign hit_vec[g] = way_valid[g] && (way_tag[g] == req_tag);
    assign way_we[g]  = install && (victim_q == WAY_W'(g));
  end

  logic                       any_hit;
  logic                       hit;
  logic                       miss_start;
  logic [LINE_BITS-1:0]       hit_line;
  logic [CORE_DATA_WIDTH-1:0] hit_word;
  logic [WAY_W-1:0]           victim_sel;
  logic                       victim_from_rr;

  assign any_hit    = |hit_vec;
  assign hit        = (state == IDLE) && i_req && any_hit;
  assign miss_start = (state == IDLE) && i_req && !any_hit && !i_flush;

  // Ways are mutually exclusive on a hit, so OR-ing masked lines selects one.
  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_line = hit_line | way_line[w];
    end
  end
  assign hit_word = hit_line[int'(req_off) * CORE_DATA_WIDTH +: CORE_DATA_WIDTH];

  // Lowest invalid way wins; only a fully valid set falls back to round-robin.
  always_comb begin
    victim_sel     = rr_ptr[req_index];
    victim_from_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim_sel     = WAY_W'(w);
        victim_from_rr = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      data_q        <= '0;
      victim_q      <= '0;
      victim_rr_q   <= 1'b0;
      flush_pending <= 1'b0;
      rr_ptr        <= '{default: '0};
    end else begin
      if (hit) data_q <= hit_word;
      case (state)
        IDLE: begin
          if (i_flush) begin
            state <= FLUSH;
          end else if (miss_start) begin
            state       <= MISS;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= line_addr;
            victim_q    <= victim_sel;
            victim_rr_q <= victim_from_rr;
          end
        end
        MISS: begin
          if (i_flush) flush_pending <= 1'b1;
          if (i_mem_done) begin
            mem_req_q <= 1'b0;
            state     <= FILL;
            if (install && victim_rr_q) begin
              rr_ptr[miss_index] <= (32'(victim_q) == 32'(WAYS - 1)) ? '0
                                    : victim_q + WAY_W'(1);
            end
          end
        end
        FILL: begin
          if (flush_now) begin
            state         <= FLUSH;
            flush_pending <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          state  <= IDLE;
          rr_ptr <= '{default: '0};
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert ($countones(hit_vec) <= 1);
    end
  end

  assign o_stall    = (state != IDLE) || (i_req && !any_hit);
  assign o_data     = hit ? hit_word : data_q;
  assign o_mem_req  = mem_req_q;
  assign o_mem_addr = mem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (hit)        o_hit_cnt  <= o_hit_cnt + 32'd1;
      if (miss_start) o_miss_cnt <= o_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
